// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the N-stage valid/ready pipeline.
package pipeline_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_STAGES = 3;

  // Bits needed to count 0..stages valid words.
  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: valid bit plus data register with load enable,
// synchronous flush and asynchronous active-low reset.
module pipe_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             flush,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_q,
  output logic [WIDTH-1:0] d_q
);

  logic             v_d;
  logic [WIDTH-1:0] d_d;

  // Next state: data only moves with a valid word; flush kills the valid bit.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (load) begin
      v_d = v_in;
      if (v_in) begin
        d_d = d_in;
      end
    end
    if (flush) begin
      v_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/pipeline_n.sv
// N-stage elastic pipeline with per-stage valid bits, a combinational
// ready chain from the downstream acknowledge, flush and occupancy count.
module pipeline_n
  import pipeline_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            DIR,
  output logic                            ack_up,
  input  logic [WIDTH-1:0]                data_in,
  output logic                            DOR,
  input  logic                            ack_down,
  output logic [WIDTH-1:0]                data_out,
  input  logic                            flush,
  output logic [occ_width(STAGES)-1:0]    occupancy
);

  localparam int unsigned OCC_W = occ_width(STAGES);

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES:0]   rdy;

  // Ready chain: a stage can load when it is empty or its successor moves.
  always_comb begin
    logic chain;
    chain       = ack_down;
    rdy         = '0;
    rdy[STAGES] = ack_down;
    for (int unsigned i = STAGES; i > 0; i--) begin
      chain    = ~v[i-1] | chain;
      rdy[i-1] = chain;
    end
  end

  // Upstream handshake: blocked during flush and while reset is held.
  always_comb begin
    ack_up = rdy[0] & ~flush & reset;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] d_in;

    if (g == 0) begin : g_first
      assign v_in = DIR & ack_up;
      assign d_in = data_in;
    end else begin : g_next
      assign v_in = v[g-1];
      assign d_in = d[g-1];
    end

    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst_n (reset),
      .load  (rdy[g]),
      .flush (flush),
      .v_in  (v_in),
      .d_in  (d_in),
      .v_q   (v[g]),
      .d_q   (d[g])
    );
  end

  // Outputs come straight from the last stage registers.
  always_comb begin
    DOR      = v[STAGES-1];
    data_out = d[STAGES-1];
  end

  // Occupancy is the population count of the registered valid bits.
  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end

endmodule

// File: tb/tb_pipeline_n.sv
// Self-checking bench for pipeline_n (WIDTH=8, STAGES=3). The reference
// model is an ordered list of in-flight words with their slot positions.
module tb_pipeline_n;

  localparam int W = 8;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         DIR;
  logic         ack_up;
  logic [W-1:0] data_in;
  logic         DOR;
  logic         ack_down;
  logic [W-1:0] data_out;
  logic         flush;
  logic [1:0]   occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } word_t;

  word_t q[$];

  pipeline_n #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .DIR       (DIR),
    .ack_up    (ack_up),
    .data_in   (data_in),
    .DOR       (DOR),
    .ack_down  (ack_down),
    .data_out  (data_out),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Upstream stalls only when every slot is full and the output is stalled.
  function automatic bit m_ack_up();
    return reset && !flush && (q.size() < S || ack_down);
  endfunction

  function automatic bit m_dor();
    return q.size() > 0 && q[0].pos == S - 1;
  endfunction

  // Drive inputs shortly after the falling edge.
  task automatic apply(input bit dir, input logic [W-1:0] din,
                       input bit ackd, input bit fl);
    @(negedge clk);
    DIR      = dir;
    data_in  = din;
    ack_down = ackd;
    flush    = fl;
    #1;
  endtask

  // Advance the model across the coming rising edge, then wait for it.
  task automatic commit();
    bit acc;
    bit drn;
    int lim;
    int np;
    acc = DIR && m_ack_up();
    drn = m_dor() && ack_down;
    if (!reset || flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      lim = S - 1;
      for (int k = 0; k < q.size(); k++) begin
        np = q[k].pos + 1;
        if (np > lim) np = lim;
        q[k].pos = np;
        lim = np - 1;
      end
      if (acc) q.push_back('{data: data_in, pos: 0});
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    DIR      = 1'b1;
    data_in  = 8'h55;
    ack_down = 1'b1;
    flush    = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (ack_up !== 1'b0) begin n_fail++; $display("FAIL reset_ack_up: got %b expected 0", ack_up); end
    n_checks++;
    if (DOR !== 1'b0) begin n_fail++; $display("FAIL reset_dor: got %b expected 0", DOR); end
    n_checks++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    n_checks++;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    DIR = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (ack_up !== 1'b1) begin n_fail++; $display("FAIL release_ack_up: got %b expected 1", ack_up); end
    commit();
  endtask

  task automatic test_latency();
    for (int c = 0; c <= 4; c++) begin
      apply(c == 0, 8'h11, 1'b1, 1'b0);
      if (c == 0) begin
        n_checks++;
        if (ack_up !== 1'b1) begin n_fail++; $display("FAIL lat_ack_up: got %b expected 1", ack_up); end
      end else begin
        n_checks++;
        if (occupancy !== ((c <= 3) ? 2'd1 : 2'd0)) begin
          n_fail++; $display("FAIL lat_occ c%0d: got %0d expected %0d", c, occupancy, (c <= 3) ? 1 : 0);
        end
        n_checks++;
        if (DOR !== (c == 3)) begin n_fail++; $display("FAIL lat_dor c%0d: got %b expected %b", c, DOR, c == 3); end
        if (c == 3) begin
          n_checks++;
          if (data_out !== 8'h11) begin n_fail++; $display("FAIL lat_data: got %h expected 11", data_out); end
        end
      end
      commit();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 14; c++) begin
      apply(c < 10, W'(c + 1), 1'b1, 1'b0);
      n_checks++;
      if (ack_up !== 1'b1) begin n_fail++; $display("FAIL b2b_ack_up c%0d: got %b expected 1", c, ack_up); end
      n_checks++;
      if (DOR !== (c >= 3 && c < 13)) begin
        n_fail++; $display("FAIL b2b_dor c%0d: got %b expected %b", c, DOR, c >= 3 && c < 13);
      end
      if (c >= 3 && c < 13) begin
        n_checks++;
        if (data_out !== W'(c - 2)) begin
          n_fail++; $display("FAIL b2b_data c%0d: got %h expected %h", c, data_out, W'(c - 2));
        end
      end
      commit();
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, W'(8'hA0 + c), 1'b0, 1'b0);
      n_checks++;
      if (ack_up !== 1'b1) begin n_fail++; $display("FAIL stall_fill_ack c%0d: got %b expected 1", c, ack_up); end
      commit();
    end
    apply(1'b1, 8'hA3, 1'b0, 1'b0);
    n_checks++;
    if (ack_up !== 1'b0) begin n_fail++; $display("FAIL stall_full_ack: got %b expected 0", ack_up); end
    n_checks++;
    if (occupancy !== 2'd3) begin n_fail++; $display("FAIL stall_full_occ: got %0d expected 3", occupancy); end
    n_checks++;
    if (DOR !== 1'b1 || data_out !== 8'hA0) begin
      n_fail++; $display("FAIL stall_head: got %b/%h expected 1/a0", DOR, data_out);
    end
    commit();
    apply(1'b1, 8'hA3, 1'b1, 1'b0);
    n_checks++;
    if (ack_up !== 1'b1) begin n_fail++; $display("FAIL stall_release_ack: got %b expected 1", ack_up); end
    n_checks++;
    if (data_out !== 8'hA0) begin n_fail++; $display("FAIL stall_release_data: got %h expected a0", data_out); end
    commit();
    apply(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (occupancy !== 2'd3) begin n_fail++; $display("FAIL stall_swap_occ: got %0d expected 3", occupancy); end
    n_checks++;
    if (DOR !== 1'b1 || data_out !== 8'hA1) begin
      n_fail++; $display("FAIL stall_next: got %b/%h expected 1/a1", DOR, data_out);
    end
    commit();
    repeat (4) begin
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      commit();
    end
    apply(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL stall_drained: got %0d expected 0", occupancy); end
    commit();
  endtask

  task automatic test_flush();
    apply(1'b1, 8'hB0, 1'b0, 1'b0);
    commit();
    apply(1'b1, 8'hB1, 1'b0, 1'b0);
    commit();
    apply(1'b1, 8'hB2, 1'b0, 1'b1);
    n_checks++;
    if (ack_up !== 1'b0) begin n_fail++; $display("FAIL flush_ack_up: got %b expected 0", ack_up); end
    n_checks++;
    if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ: got %0d expected 2", occupancy); end
    commit();
    apply(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
    commit();
    for (int c = 0; c < 5; c++) begin
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (DOR !== 1'b0) begin n_fail++; $display("FAIL flush_dor c%0d: got %b data %h expected 0", c, DOR, data_out); end
      commit();
    end
  endtask

  task automatic test_async_reset();
    apply(1'b1, 8'hC0, 1'b0, 1'b0);
    commit();
    apply(1'b1, 8'hC1, 1'b0, 1'b0);
    commit();
    apply(1'b0, 8'h00, 1'b0, 1'b0);
    commit();
    apply(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (DOR !== 1'b1 || occupancy !== 2'd2) begin
      n_fail++; $display("FAIL areset_pre: got dor %b occ %0d expected 1/2", DOR, occupancy);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (DOR !== 1'b0) begin n_fail++; $display("FAIL areset_dor: got %b expected 0", DOR); end
    n_checks++;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL areset_occ: got %0d expected 0", occupancy); end
    n_checks++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL areset_data: got %h expected 00", data_out); end
    n_checks++;
    if (ack_up !== 1'b0) begin n_fail++; $display("FAIL areset_ack: got %b expected 0", ack_up); end
    q.delete();
    #1 reset = 1'b1;
    commit();
    apply(1'b1, 8'hC5, 1'b1, 1'b0);
    n_checks++;
    if (ack_up !== 1'b1) begin n_fail++; $display("FAIL areset_push_ack: got %b expected 1", ack_up); end
    commit();
    for (int c = 1; c <= 3; c++) begin
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (DOR !== (c == 3)) begin n_fail++; $display("FAIL areset_lat c%0d: got %b expected %b", c, DOR, c == 3); end
      if (c == 3) begin
        n_checks++;
        if (data_out !== 8'hC5) begin n_fail++; $display("FAIL areset_c5: got %h expected c5", data_out); end
      end
      commit();
    end
  endtask

  task automatic test_random();
    bit dir;
    bit ackd;
    bit fl;
    for (int c = 0; c < 10000; c++) begin
      dir  = 1'($urandom_range(0, 1));
      ackd = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 63) == 0);
      apply(dir, W'($urandom), ackd, fl);
      n_checks++;
      if (ack_up !== m_ack_up()) begin
        n_fail++; $display("FAIL rand_ack_up c%0d: got %b expected %b", c, ack_up, m_ack_up());
      end
      n_checks++;
      if (DOR !== m_dor()) begin n_fail++; $display("FAIL rand_dor c%0d: got %b expected %b", c, DOR, m_dor()); end
      n_checks++;
      if (occupancy !== 2'(q.size())) begin
        n_fail++; $display("FAIL rand_occ c%0d: got %0d expected %0d", c, occupancy, q.size());
      end
      if (m_dor()) begin
        n_checks++;
        if (data_out !== q[0].data) begin
          n_fail++; $display("FAIL rand_data c%0d: got %h expected %h", c, data_out, q[0].data);
        end
      end
      commit();
    end
    for (int c = 0; c < 2 * S; c++) begin
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      if (m_dor()) begin
        n_checks++;
        if (data_out !== q[0].data) begin
          n_fail++; $display("FAIL drain_data c%0d: got %h expected %h", c, data_out, q[0].data);
        end
      end
      commit();
    end
    apply(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (occupancy !== 2'd0 || q.size() != 0) begin
      n_fail++; $display("FAIL drain_empty: got occ %0d model %0d expected 0", occupancy, q.size());
    end
    commit();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
